// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S frame-level blocks.
//   state_t          frame sequencer state (IDLE, SYNC, RUN) in 2 bits
//   PDATA_WIDTH_DEF  default channel sample width, matching i2s_trx
package i2s_pkg;

    localparam int unsigned PDATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_edge_det.sv
// i2s_edge_det: LRCK falling-edge tick generator.
// LRCK is registered once; tick is high in the first cycle the live LRCK is
// seen low after having been high (right channel of the frame complete).
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (clears the LRCK history)
//   lrck  in   LRCK from the transceiver
//   tick  out  combinational one-cycle frame-boundary strobe
module i2s_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic lrck,
    output logic tick
);

    logic lrck_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lrck_q <= 1'b0;
        end else begin
            lrck_q <= lrck;
        end
    end

    assign tick = lrck_q & ~lrck;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// i2s_frame_ctrl: frame sequencer between i2s_trx and the DSP datapath.
// Captures every completed RX stereo frame into a valid/ready output stream
// and feeds TX stereo frames from a valid/ready input stream to the
// transceiver at LRCK frame boundaries. The first boundary after enable only
// aligns (partial frame); overrun/underrun are flagged with one-cycle pulses.
// Optional: define I2S_FRAME_CTRL_STATS_EN to add saturating event counters.
// Ports:
//   mclk_in, rst_in, en_in            clock, sync active-high reset, enable
//   lrck_in                           LRCK (low = left, high = right)
//   rx_pldata_in, rx_prdata_in        received samples from i2s_trx
//   tx_pldata_out, tx_prdata_out      transmit samples to i2s_trx
//   m_pldata_out, m_prdata_out,
//   m_valid_out, m_ready_in           RX output stream
//   s_pldata_in, s_prdata_in,
//   s_valid_in, s_ready_out           TX input stream
//   run_out                           high in RUN
//   overrun_out, underrun_out         one-cycle event pulses
//   ovr_cnt_out, udr_cnt_out          event counters (stats build only)
module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int unsigned PDATA_WIDTH = PDATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   mclk_in,
    input  logic                   rst_in,
    input  logic                   en_in,
    input  logic                   lrck_in,
    input  logic [PDATA_WIDTH-1:0] rx_pldata_in,
    input  logic [PDATA_WIDTH-1:0] rx_prdata_in,
    output logic [PDATA_WIDTH-1:0] tx_pldata_out,
    output logic [PDATA_WIDTH-1:0] tx_prdata_out,
    output logic [PDATA_WIDTH-1:0] m_pldata_out,
    output logic [PDATA_WIDTH-1:0] m_prdata_out,
    output logic                   m_valid_out,
    input  logic                   m_ready_in,
    input  logic [PDATA_WIDTH-1:0] s_pldata_in,
    input  logic [PDATA_WIDTH-1:0] s_prdata_in,
    input  logic                   s_valid_in,
    output logic                   s_ready_out,
    output logic                   run_out,
    output logic                   overrun_out,
`ifdef I2S_FRAME_CTRL_STATS_EN
    output logic [CNT_WIDTH-1:0]   ovr_cnt_out,
    output logic [CNT_WIDTH-1:0]   udr_cnt_out,
`endif
    output logic                   underrun_out
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    state_t                 state;
    logic                   tick;
    logic                   full;
    logic [PDATA_WIDTH-1:0] hold_l;
    logic [PDATA_WIDTH-1:0] hold_r;
    logic                   run_tick;
    logic                   ovr_evt;
    logic                   udr_evt;
    logic                   accept;

    i2s_edge_det u_edge_det (
        .clk  (mclk_in),
        .rst  (rst_in),
        .lrck (lrck_in),
        .tick (tick)
    );

    assign run_out     = (state == RUN);
    assign s_ready_out = (state != IDLE) & ~full;

    // Events are judged on pre-edge state; disabling suppresses them.
    always_comb begin
        run_tick = (state == RUN) & en_in & tick;
        ovr_evt  = run_tick & m_valid_out & ~m_ready_in;
        udr_evt  = run_tick & ~full;
        accept   = s_valid_in & s_ready_out & en_in;
    end

    always_ff @(posedge mclk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            m_pldata_out  <= '0;
            m_prdata_out  <= '0;
            m_valid_out   <= 1'b0;
            tx_pldata_out <= '0;
            tx_prdata_out <= '0;
            hold_l        <= '0;
            hold_r        <= '0;
            full          <= 1'b0;
            overrun_out   <= 1'b0;
            underrun_out  <= 1'b0;
        end else begin
            overrun_out  <= ovr_evt;
            underrun_out <= udr_evt;
            case (state)
                IDLE: begin
                    m_valid_out   <= 1'b0;
                    tx_pldata_out <= '0;
                    tx_prdata_out <= '0;
                    full          <= 1'b0;
                    if (en_in) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (!en_in) begin
                        state <= IDLE;
                        full  <= 1'b0;
                    end else begin
                        // First boundary only aligns; its frame is partial.
                        if (tick) begin
                            state <= RUN;
                        end
                        if (accept) begin
                            hold_l <= s_pldata_in;
                            hold_r <= s_prdata_in;
                            full   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!en_in) begin
                        state         <= IDLE;
                        m_valid_out   <= 1'b0;
                        full          <= 1'b0;
                        tx_pldata_out <= '0;
                        tx_prdata_out <= '0;
                    end else begin
                        if (tick) begin
                            m_pldata_out <= rx_pldata_in;
                            m_prdata_out <= rx_prdata_in;
                            m_valid_out  <= 1'b1;
                            if (full) begin
                                tx_pldata_out <= hold_l;
                                tx_prdata_out <= hold_r;
                                full          <= 1'b0;
                            end else begin
                                tx_pldata_out <= '0;
                                tx_prdata_out <= '0;
                            end
                        end else if (m_valid_out && m_ready_in) begin
                            m_valid_out <= 1'b0;
                        end
                        // Accept only happens when full was clear, so a write
                        // in a tick cycle refills holding for the next frame.
                        if (accept) begin
                            hold_l <= s_pldata_in;
                            hold_r <= s_prdata_in;
                            full   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef I2S_FRAME_CTRL_STATS_EN
    // Counters advance on the same edge that raises the matching pulse.
    always_ff @(posedge mclk_in) begin
        if (rst_in || (state == IDLE && en_in)) begin
            ovr_cnt_out <= '0;
            udr_cnt_out <= '0;
        end else begin
            if (ovr_evt && (ovr_cnt_out != '1)) begin
                ovr_cnt_out <= ovr_cnt_out + CNT_WIDTH'(1);
            end
            if (udr_evt && (udr_cnt_out != '1)) begin
                udr_cnt_out <= udr_cnt_out + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// tb_i2s_frame_ctrl: scoreboard bench for i2s_frame_ctrl.
// The driver pushes one expectation record per LRCK falling edge and one
// entry per RX frame it intends to consume; an independent monitor detects
// frame boundaries from LRCK and RX handshakes, pops and compares.
// Stats counters are checked when I2S_FRAME_CTRL_STATS_EN is defined.
module tb_i2s_frame_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;

    logic         mclk = 1'b0;
    logic         rst, en, lrck;
    logic [W-1:0] rx_l, rx_r, tx_l, tx_r, m_l, m_r, s_l, s_r;
    logic         m_valid, m_ready, s_valid, s_ready, run, ovr, udr;
`ifdef I2S_FRAME_CTRL_STATS_EN
    logic [CW-1:0] ovr_cnt, udr_cnt;
`endif

    always #5 mclk = ~mclk;

    i2s_frame_ctrl #(.PDATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .mclk_in       (mclk),
        .rst_in        (rst),
        .en_in         (en),
        .lrck_in       (lrck),
        .rx_pldata_in  (rx_l),
        .rx_prdata_in  (rx_r),
        .tx_pldata_out (tx_l),
        .tx_prdata_out (tx_r),
        .m_pldata_out  (m_l),
        .m_prdata_out  (m_r),
        .m_valid_out   (m_valid),
        .m_ready_in    (m_ready),
        .s_pldata_in   (s_l),
        .s_prdata_in   (s_r),
        .s_valid_in    (s_valid),
        .s_ready_out   (s_ready),
        .run_out       (run),
        .overrun_out   (ovr),
`ifdef I2S_FRAME_CTRL_STATS_EN
        .ovr_cnt_out   (ovr_cnt),
        .udr_cnt_out   (udr_cnt),
`endif
        .underrun_out  (udr)
    );

    typedef struct {
        logic [W-1:0] txl, txr, ml, mr;
        logic         udr, ovr, mv, sr, run;
        int unsigned  ovc, udc;
    } rec_t;

    rec_t         tick_q[$];
    logic [63:0]  rx_q[$];
    int unsigned  n_total = 0;
    int unsigned  n_pass  = 0;
    logic         mon_prev = 1'b0;
    bit           p1 = 1'b0, p2 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic rec_t mk(input logic [W-1:0] txl, txr, ml, mr,
                                input logic u, o, mv, sr, rn,
                                input int unsigned oc, uc);
        rec_t r;
        r.txl = txl; r.txr = txr; r.ml = ml; r.mr = mr;
        r.udr = u; r.ovr = o; r.mv = mv; r.sr = sr; r.run = rn;
        r.ovc = oc; r.udc = uc;
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // High half-frame, then queue the boundary expectation and drop LRCK;
    // on return the current cycle is the tick cycle.
    task automatic hi_fall(input rec_t r);
        lrck = 1'b1;
        cyc(128);
        tick_q.push_back(r);
        lrck = 1'b0;
    endtask

    // Monitor: samples on the falling clock edge.
    initial begin
        rec_t        cur;
        logic [63:0] exp_rx;
        forever begin
            @(negedge mclk);
            if (m_valid && m_ready) begin
                if (rx_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rx_pop: unexpected handshake got %0h want none", {m_l, m_r});
                end else begin
                    exp_rx = rx_q.pop_front();
                    chk("rx_data", {m_l, m_r}, exp_rx);
                end
            end
            if (p2) begin
                chk("ovr_pulse_end", 64'(ovr), 64'd0);
                chk("udr_pulse_end", 64'(udr), 64'd0);
                p2 = 1'b0;
            end
            if (p1) begin
                p1 = 1'b0;
                if (tick_q.size() == 0) begin
                    n_total++;
                    $display("FAIL tick_pop: boundary got unexpected want queued record");
                end else begin
                    cur = tick_q.pop_front();
                    chk("tick_tx", {tx_l, tx_r}, {cur.txl, cur.txr});
                    chk("tick_udr", 64'(udr), 64'(cur.udr));
                    chk("tick_ovr", 64'(ovr), 64'(cur.ovr));
                    chk("tick_mvalid", 64'(m_valid), 64'(cur.mv));
                    if (cur.mv) chk("tick_mdata", {m_l, m_r}, {cur.ml, cur.mr});
                    chk("tick_sready", 64'(s_ready), 64'(cur.sr));
                    chk("tick_run", 64'(run), 64'(cur.run));
`ifdef I2S_FRAME_CTRL_STATS_EN
                    chk("tick_ovr_cnt", 64'(ovr_cnt), 64'(cur.ovc));
                    chk("tick_udr_cnt", 64'(udr_cnt), 64'(cur.udc));
`endif
                    p2 = 1'b1;
                end
            end
            if (mon_prev && !lrck) p1 = 1'b1;
            mon_prev = lrck;
        end
    end

    initial begin
        repeat (20000) @(posedge mclk);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mdata"}, {m_l, m_r}, 64'd0);
        chk({tag, "_tx"}, {tx_l, tx_r}, 64'd0);
        chk({tag, "_flags"}, {59'd0, m_valid, s_ready, run, ovr, udr}, 64'd0);
`ifdef I2S_FRAME_CTRL_STATS_EN
        chk({tag, "_cnts"}, {32'd0, ovr_cnt, udr_cnt}, 64'd0);
`endif
    endtask

    localparam logic [W-1:0] F0L = 32'h1111_0000, F0R = 32'h2222_0000;
    localparam logic [W-1:0] AL  = 32'h3333_0001, AR  = 32'h4444_0002;
    localparam logic [W-1:0] BL  = 32'h5555_0003, BR  = 32'h6666_0004;
    localparam logic [W-1:0] CL  = 32'h7777_0005, CR  = 32'h8888_0006;
    localparam logic [W-1:0] EL  = 32'h9999_0007, ER  = 32'hAAAA_0008;
    localparam logic [W-1:0] FL  = 32'hBBBB_000B, FR  = 32'hCCCC_000C;
    localparam logic [W-1:0] TAL = 32'hA5A5_0001, TAR = 32'h5A5A_0002;
    localparam logic [W-1:0] DL  = 32'hDEAD_0009, DR  = 32'hBEEF_000A;
    localparam logic [W-1:0] GL  = 32'h1234_5678, GR  = 32'h8765_4321;

    // Driver
    initial begin
        rst = 1'b1; en = 1'b0; lrck = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
        rx_l = '0; rx_r = '0; s_l = '0; s_r = '0;
        cyc(3);
        chk_reset_vals("reset");
        rst = 1'b0; en = 1'b1;
        cyc(1);
        chk("sync_sready", 64'(s_ready), 64'd1);
        chk("sync_run", 64'(run), 64'd0);

        // Alignment boundary, then first captured frame with TX underrun.
        rx_l = F0L; rx_r = F0R;
        hi_fall(mk('0, '0, '0, '0, 0, 0, 0, 1, 1, 0, 0));
        cyc(128);
        hi_fall(mk('0, '0, F0L, F0R, 1, 0, 1, 1, 1, 0, 1));
        cyc(128);
        // Two unconsumed frames: each overwrites the previous.
        rx_l = AL; rx_r = AR;
        hi_fall(mk('0, '0, AL, AR, 1, 1, 1, 1, 1, 1, 2));
        cyc(128);
        rx_l = BL; rx_r = BR;
        hi_fall(mk('0, '0, BL, BR, 1, 1, 1, 1, 1, 2, 3));
        cyc(3);
        rx_q.push_back({BL, BR});
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        // Preload a TX frame.
        s_l = TAL; s_r = TAR; s_valid = 1'b1;
        cyc(1);
        s_valid = 1'b0;
        chk("preload_sready", 64'(s_ready), 64'd0);
        chk("consumed_mvalid", 64'(m_valid), 64'd0);
        cyc(123);
        rx_l = CL; rx_r = CR;
        hi_fall(mk(TAL, TAR, CL, CR, 0, 0, 1, 1, 1, 2, 3));
        cyc(128);
        // TX write and RX accept in the tick cycle itself.
        rx_l = EL; rx_r = ER;
        hi_fall(mk('0, '0, EL, ER, 1, 0, 1, 0, 1, 2, 4));
        rx_q.push_back({CL, CR});
        m_ready = 1'b1;
        s_l = DL; s_r = DR; s_valid = 1'b1;
        cyc(1);
        m_ready = 1'b0; s_valid = 1'b0;
        cyc(127);
        rx_l = FL; rx_r = FR;
        hi_fall(mk(DL, DR, FL, FR, 0, 1, 1, 1, 1, 3, 4));
        cyc(3);
        // Disable mid-RUN with a pending RX frame and full holding register.
        s_l = GL; s_r = GR; s_valid = 1'b1;
        cyc(1);
        s_valid = 1'b0;
        chk("pre_dis_sready", 64'(s_ready), 64'd0);
        chk("pre_dis_mvalid", 64'(m_valid), 64'd1);
        en = 1'b0;
        cyc(1);
        chk("dis_tx", {tx_l, tx_r}, 64'd0);
        chk("dis_flags", {60'd0, m_valid, s_ready, run, ovr | udr}, 64'd0);
        cyc(2);
        en = 1'b1;
        cyc(1);
        chk("reen_sready", 64'(s_ready), 64'd1);
`ifdef I2S_FRAME_CTRL_STATS_EN
        chk("reen_cnts", {32'd0, ovr_cnt, udr_cnt}, 64'd0);
`endif
        cyc(120);
        hi_fall(mk('0, '0, '0, '0, 0, 0, 0, 1, 1, 0, 0));
        cyc(128);
        // Holding was cleared on disable, so this boundary underruns.
        hi_fall(mk('0, '0, FL, FR, 1, 0, 1, 1, 1, 0, 1));
        cyc(4);
        rst = 1'b1; en = 1'b0;
        cyc(1);
        chk_reset_vals("run_reset");
        rst = 1'b0;
        cyc(5);
        chk("end_tick_q", 64'(tick_q.size()), 64'd0);
        chk("end_rx_q", 64'(rx_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2s_frame_ctrl.md
Name: i2s_frame_ctrl

Overview:
Frame sequencer between the i2s_trx transceiver and the DSP datapath. It detects LRCK frame boundaries in the MCLK domain and captures each completed RX stereo frame into a valid/ready output stream. It also accepts TX stereo frames over a valid/ready input and presents them to the transceiver's parallel inputs at frame boundaries. It handles start-up alignment, overrun and underrun.

Parameters:
PDATA_WIDTH, 32, width of each channel sample (matches i2s_trx PDATA_WIDTH)
CNT_WIDTH, 16, width of optional saturating event counters

Ports:
mclk_in  in  1  master clock; all logic on rising edge
rst_in  in  1  synchronous active-high reset
en_in  in  1  controller enable
lrck_in  in  1  LRCK from i2s_trx (low = left, high = right)
rx_pldata_in  in  PDATA_WIDTH  i2s_trx received left sample
rx_prdata_in  in  PDATA_WIDTH  i2s_trx received right sample
tx_pldata_out  out  PDATA_WIDTH  to i2s_trx left transmit sample
tx_prdata_out  out  PDATA_WIDTH  to i2s_trx right transmit sample
m_pldata_out  out  PDATA_WIDTH  RX stream left
m_prdata_out  out  PDATA_WIDTH  RX stream right
m_valid_out  out  1  RX stream valid
m_ready_in  in  1  RX stream ready
s_pldata_in  in  PDATA_WIDTH  TX stream left
s_prdata_in  in  PDATA_WIDTH  TX stream right
s_valid_in  in  1  TX stream valid
s_ready_out  out  1  TX stream ready
run_out  out  1  high in RUN state
overrun_out  out  1  one-cycle pulse: unconsumed RX frame overwritten
underrun_out  out  1  one-cycle pulse: no TX frame available at boundary

Behaviour:
- Clock and reset: one clock, mclk_in. rst_in is synchronous and active-high.
- Reset values: all data outputs 0; m_valid_out, s_ready_out, run_out, overrun_out, underrun_out all 0; FSM in IDLE; lrck_q = 0; tx holding register empty.
- Frame tick:
  - lrck_q registers lrck_in.
  - tick = lrck_q & ~lrck_in (falling LRCK, i.e. right channel complete). tick is combinational, valid in the cycle where lrck_in is first seen low.
- FSM IDLE:
  - m_valid_out = 0, s_ready_out = 0, tx outputs 0.
  - en_in = 1 moves to SYNC.
- FSM SYNC:
  - Waits for the first tick. No capture on that tick, because the frame is partial.
  - On tick, go to RUN.
  - en_in = 0 returns to IDLE.
  - s_ready_out = 1 from SYNC onward, so the first TX frame can be preloaded.
- FSM RUN, on each tick:
  - RX capture:
    - rx_pldata_in/rx_prdata_in are loaded into m_*data_out and m_valid_out = 1, visible the cycle after the tick.
    - If m_valid_out = 1 and m_ready_in = 0 at the tick: overwrite the old frame and pulse overrun_out for 1 cycle.
    - If m_ready_in = 1 at the tick: the old frame is accepted, the new frame is loaded, and m_valid_out stays 1 with no overrun.
  - TX load:
    - If the holding register is full, copy it to tx_*data_out and clear full.
    - If empty, drive tx_*data_out = 0 (mute) and pulse underrun_out.
    - Updated outputs are visible the cycle after the tick.
  - The TX decision uses the pre-edge full flag. A write accepted in the same cycle as the tick lands in holding for the next frame and does not cancel that tick's underrun.
- RX handshake: m_valid_out clears on m_valid_out & m_ready_in when no tick occurs that cycle.
- TX handshake:
  - s_ready_out = ~full in SYNC/RUN.
  - Accept on s_valid_in & s_ready_out; data is latched into holding and full is set.
- en_in = 0 in RUN:
  - Next cycle go to IDLE.
  - Drop m_valid_out, clear holding, zero tx outputs.
  - Any frame in flight is discarded with no pulses.
- rst_in in any state returns to the reset values on the next edge and overrides all other events.
- No arithmetic on samples; data passes bit-exact.

Optional Feature:
- Macro: I2S_FRAME_CTRL_STATS_EN.
- With it defined:
  - Adds ports ovr_cnt_out and udr_cnt_out, each CNT_WIDTH wide.
  - Each is a saturating count of overrun_out / underrun_out pulses. They stick at all-ones.
  - Cleared by rst_in and on the IDLE→SYNC transition.
- Without it: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package i2s_pkg:
  - FSM state typedef {IDLE, SYNC, RUN} in 2 bits.
  - Default PDATA_WIDTH constant.
- Sub-module i2s_edge_det: registered LRCK falling-edge tick generator, reusable by other I2S blocks.
- Holding register and stream logic stay inline.

Test Plan:
1. Reset then en_in = 1; toggle lrck_in every 128 mclk; drive rx_pldata_in = 32'h1111_0000, rx_prdata_in = 32'h2222_0000 → first tick: no m_valid_out; second tick: m_valid_out = 1 next cycle with those values; run_out = 1 after the first tick.
2. Hold m_ready_in = 0 across two RUN ticks with RX values A then B → overrun_out pulses 1 cycle at the second tick+1; m_*data_out = B.
3. Preload TX with s_pldata_in = 32'hA5A5_0001, s_prdata_in = 32'h5A5A_0002, then tick → tx outputs equal those values at tick+1; s_ready_out returns to 1; no underrun.
4. No TX write before a RUN tick → tx outputs 0 and underrun_out pulses; with I2S_FRAME_CTRL_STATS_EN, udr_cnt_out increments by 1.
5. Assert s_valid_in in the same cycle as a tick with holding empty → underrun pulses; the written frame appears on tx outputs at the next tick.
6. Drop en_in mid-RUN with m_valid_out = 1 and holding full → next cycle IDLE: m_valid_out = 0, s_ready_out = 0, tx outputs 0; also assert rst_in during RUN → all outputs at reset values next edge.
